// File: rtl/cache_bus_mem_responder.sv
// Responder end of the DCache line bus: 2-beat refill reads and 2-beat writebacks
// against an internal 128-bit line store, with a backdoor preload/peek port.
module cache_bus_mem_responder #(
    parameter int unsigned MEM_LINES     = 1024,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_bus_r_valid,
    input  logic [63:0]   io_bus_r_bits_raddr,
    output logic          io_bus_r_ready,
    output logic [63:0]   io_bus_r_bits_rdata,
    output logic          io_bus_r_bits_rlast,
    input  logic          io_bus_w_valid,
    input  logic [63:0]   io_bus_w_bits_waddr,
    input  logic [63:0]   io_bus_w_bits_wdata,
    input  logic          io_bus_w_bits_wlast,
    output logic          io_bus_w_ready,
    output logic          io_bus_b_valid,
    input  logic          io_bus_b_ready,
    input  logic          io_init_we,
    input  logic [63:0]   io_init_addr,
    input  logic [127:0]  io_init_wdata,
    output logic [127:0]  io_peek_rdata,
    output logic          io_busy,
    output logic          io_proto_err
);

    localparam int unsigned IW = $clog2(MEM_LINES);

    typedef enum logic [2:0] {
        IDLE, W_BEAT0, W_BEAT1, W_WAIT, W_RESP, R_WAIT, R_BEAT0, R_BEAT1
    } state_t;

    state_t         state_q, state_n;
    logic [127:0]   mem [MEM_LINES];
    logic [IW-1:0]  idx_q, r_idx, w_idx, init_idx, load_idx;
    logic [127:0]   load_line, commit_data;
    logic [63:0]    line_hi_q, wlo_q, whi_q, rdata_q;
    logic [15:0]    cnt_q;
    logic           proto_err_q;
    logic           latch_w, latch_r, cap_lo, cap_hi, load_en, beat1_adv;
    logic           commit, set_err, cnt_clr, cnt_inc;
    logic           unused_addr_bits;

    assign r_idx    = io_bus_r_bits_raddr[4 +: IW];
    assign w_idx    = io_bus_w_bits_waddr[4 +: IW];
    assign init_idx = io_init_addr[4 +: IW];
    assign unused_addr_bits = ^{io_bus_r_bits_raddr[63:4+IW], io_bus_r_bits_raddr[3:0],
                                io_bus_w_bits_waddr[63:4+IW], io_bus_w_bits_waddr[3:0],
                                io_init_addr[63:4+IW], io_init_addr[3:0]};

    // With zero read latency the line is fetched straight from the request address in IDLE
    assign load_idx    = (state_q == IDLE) ? r_idx : idx_q;
    assign load_line   = mem[load_idx];
    assign commit_data = (state_q == W_BEAT1) ? {io_bus_w_bits_wdata, wlo_q} : {whi_q, wlo_q};

    assign io_peek_rdata       = mem[init_idx];
    assign io_bus_r_bits_rdata = rdata_q;
    assign io_busy             = (state_q != IDLE);
    assign io_proto_err        = proto_err_q;

    always_comb begin
        state_n        = state_q;
        latch_w        = 1'b0;
        latch_r        = 1'b0;
        cap_lo         = 1'b0;
        cap_hi         = 1'b0;
        load_en        = 1'b0;
        beat1_adv      = 1'b0;
        commit         = 1'b0;
        set_err        = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        io_bus_w_ready = 1'b0;
        io_bus_r_ready = 1'b0;
        io_bus_r_bits_rlast = 1'b0;
        io_bus_b_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_bus_w_valid) begin
                    latch_w = 1'b1;
                    state_n = W_BEAT0;
                end else if (io_bus_r_valid) begin
                    latch_r = 1'b1;
                    if (READ_LATENCY == 0) begin
                        load_en = 1'b1;
                        state_n = R_BEAT0;
                    end else begin
                        cnt_clr = 1'b1;
                        state_n = R_WAIT;
                    end
                end
            end
            W_BEAT0: begin
                io_bus_w_ready = io_bus_w_valid;
                if (io_bus_w_valid) begin
                    cap_lo  = 1'b1;
                    set_err = io_bus_w_bits_wlast;
                    state_n = W_BEAT1;
                end
            end
            W_BEAT1: begin
                io_bus_w_ready = io_bus_w_valid;
                if (io_bus_w_valid) begin
                    cap_hi  = 1'b1;
                    set_err = !io_bus_w_bits_wlast;
                    if (WRITE_LATENCY == 0) begin
                        commit  = 1'b1;
                        state_n = W_RESP;
                    end else begin
                        cnt_clr = 1'b1;
                        state_n = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (cnt_q == 16'(WRITE_LATENCY - 1)) begin
                    commit  = 1'b1;
                    state_n = W_RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            W_RESP: begin
                io_bus_b_valid = 1'b1;
                if (io_bus_b_ready) state_n = IDLE;
            end
            R_WAIT: begin
                // Wait spans READ_LATENCY+1 cycles so beat 0 lands 2+READ_LATENCY after the request
                if (cnt_q == 16'(READ_LATENCY)) begin
                    load_en = 1'b1;
                    state_n = R_BEAT0;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            R_BEAT0: begin
                io_bus_r_ready = 1'b1;
                if (!io_bus_r_valid) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else begin
                    beat1_adv = 1'b1;
                    state_n   = R_BEAT1;
                end
            end
            R_BEAT1: begin
                io_bus_r_ready      = 1'b1;
                io_bus_r_bits_rlast = 1'b1;
                state_n             = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wlo_q       <= '0;
            whi_q       <= '0;
            line_hi_q   <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (latch_w)      idx_q <= w_idx;
            else if (latch_r) idx_q <= r_idx;
            if (cap_lo) wlo_q <= io_bus_w_bits_wdata;
            if (cap_hi) whi_q <= io_bus_w_bits_wdata;
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 16'd1;
            if (load_en) begin
                line_hi_q <= load_line[127:64];
                rdata_q   <= load_line[63:0];
            end
            if (beat1_adv) rdata_q <= line_hi_q;
            if (set_err) proto_err_q <= 1'b1;
        end
    end

    // Array is never cleared; reset blocks the commit so a partial write is dropped
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (commit)
                mem[idx_q] <= commit_data;
            else if (state_q == IDLE && io_init_we)
                mem[init_idx] <= io_init_wdata;
        end
    end

endmodule

// File: tb/tb_cache_bus_mem_responder.sv
// Directed bench for cache_bus_mem_responder: default-latency instance (0) and
// zero-latency instance (1), read beats checked against a scoreboard queue.
module tb_cache_bus_mem_responder;

    logic               clock = 1'b0;
    logic [1:0]         reset;
    logic [1:0]         r_valid, w_valid, wlast, b_ready, init_we;
    logic [1:0][63:0]   raddr, waddr, wdata, init_addr;
    logic [1:0][127:0]  init_wdata;
    wire  [1:0]         r_ready, rlast, w_ready, b_valid, busy, proto_err;
    wire  [1:0][63:0]   rdata;
    wire  [1:0][127:0]  peek;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t        rd_q[$];
    logic [127:0] model [2][1024];
    int           n_asserts = 0;
    int           n_fail = 0;

    always #5 clock = ~clock;

    cache_bus_mem_responder #(.MEM_LINES(1024), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut_slow (
        .clock(clock), .reset(reset[0]),
        .io_bus_r_valid(r_valid[0]), .io_bus_r_bits_raddr(raddr[0]), .io_bus_r_ready(r_ready[0]),
        .io_bus_r_bits_rdata(rdata[0]), .io_bus_r_bits_rlast(rlast[0]),
        .io_bus_w_valid(w_valid[0]), .io_bus_w_bits_waddr(waddr[0]), .io_bus_w_bits_wdata(wdata[0]),
        .io_bus_w_bits_wlast(wlast[0]), .io_bus_w_ready(w_ready[0]),
        .io_bus_b_valid(b_valid[0]), .io_bus_b_ready(b_ready[0]),
        .io_init_we(init_we[0]), .io_init_addr(init_addr[0]), .io_init_wdata(init_wdata[0]),
        .io_peek_rdata(peek[0]), .io_busy(busy[0]), .io_proto_err(proto_err[0])
    );

    cache_bus_mem_responder #(.MEM_LINES(1024), .READ_LATENCY(0), .WRITE_LATENCY(0)) dut_fast (
        .clock(clock), .reset(reset[1]),
        .io_bus_r_valid(r_valid[1]), .io_bus_r_bits_raddr(raddr[1]), .io_bus_r_ready(r_ready[1]),
        .io_bus_r_bits_rdata(rdata[1]), .io_bus_r_bits_rlast(rlast[1]),
        .io_bus_w_valid(w_valid[1]), .io_bus_w_bits_waddr(waddr[1]), .io_bus_w_bits_wdata(wdata[1]),
        .io_bus_w_bits_wlast(wlast[1]), .io_bus_w_ready(w_ready[1]),
        .io_bus_b_valid(b_valid[1]), .io_bus_b_ready(b_ready[1]),
        .io_init_we(init_we[1]), .io_init_addr(init_addr[1]), .io_init_wdata(init_wdata[1]),
        .io_peek_rdata(peek[1]), .io_busy(busy[1]), .io_proto_err(proto_err[1])
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int i);
        check("zero_r_ready",   128'(r_ready[i]),   128'(0));
        check("zero_rlast",     128'(rlast[i]),     128'(0));
        check("zero_w_ready",   128'(w_ready[i]),   128'(0));
        check("zero_b_valid",   128'(b_valid[i]),   128'(0));
        check("zero_busy",      128'(busy[i]),      128'(0));
        check("zero_proto_err", 128'(proto_err[i]), 128'(0));
        check("zero_rdata",     128'(rdata[i]),     128'(0));
    endtask

    task automatic do_reset(input int i);
        reset[i] = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset[i] = 1'b0;
    endtask

    task automatic preload(input int i, input logic [63:0] a, input logic [127:0] d);
        init_we[i] = 1'b1; init_addr[i] = a; init_wdata[i] = d;
        @(posedge clock);
        #1 init_we[i] = 1'b0;
        model[i][a[13:4]] = d;
    endtask

    task automatic peek_check(input int i, input logic [63:0] a, input string tag);
        init_addr[i] = a;
        #1 check(tag, peek[i], model[i][a[13:4]]);
    endtask

    // One transaction: optional write and/or read presented together at cycle 0
    task automatic xact(input int i, input bit do_w, input logic [63:0] wa, input logic [127:0] wd,
                        input bit wl0, input bit wl1, input bit do_r, input logic [63:0] ra,
                        input int b_cyc, input int r_cyc);
        int    wbeats, rbeats, cyc;
        bit    bdone;
        beat_t e;
        if (do_w) model[i][wa[13:4]] = wd;
        if (do_r) begin
            e.data = model[i][ra[13:4]][63:0];   e.last = 1'b0; rd_q.push_back(e);
            e.data = model[i][ra[13:4]][127:64]; e.last = 1'b1; rd_q.push_back(e);
        end
        w_valid[i] = do_w; waddr[i] = wa; wdata[i] = wd[63:0]; wlast[i] = wl0;
        r_valid[i] = do_r; raddr[i] = ra; b_ready[i] = 1'b1;
        wbeats = do_w ? 0 : 2;
        rbeats = do_r ? 0 : 2;
        bdone  = !do_w;
        cyc    = 0;
        while ((wbeats < 2 || !bdone || rbeats < 2) && cyc < 40) begin
            @(negedge clock);
            if (w_valid[i] && w_ready[i]) begin
                check("w_beat_cycle", 128'(cyc), 128'(1 + wbeats));
                wbeats++;
            end
            if (b_valid[i] && b_ready[i]) begin
                check("b_cycle", 128'(cyc), 128'(b_cyc));
                bdone = 1'b1;
            end
            if (r_valid[i] && r_ready[i]) begin
                if (rd_q.size() == 0) begin
                    check("r_unexpected_beat", 128'(1), 128'(0));
                end else begin
                    e = rd_q.pop_front();
                    check("r_data",  128'(rdata[i]), 128'(e.data));
                    check("r_last",  128'(rlast[i]), 128'(e.last));
                    check("r_cycle", 128'(cyc), 128'(r_cyc + rbeats));
                end
                rbeats++;
            end else begin
                check("r_last_idle", 128'(rlast[i]), 128'(0));
            end
            @(posedge clock);
            #1 cyc++;
            if (wbeats == 1) begin wdata[i] = wd[127:64]; wlast[i] = wl1; end
            if (wbeats == 2) w_valid[i] = 1'b0;
            if (rbeats == 2) r_valid[i] = 1'b0;
        end
        check("xact_complete", 128'(wbeats == 2 && bdone && rbeats == 2), 128'(1));
        w_valid[i] = 1'b0; r_valid[i] = 1'b0; b_ready[i] = 1'b0; wlast[i] = 1'b0;
        @(negedge clock);
        check("r_last_after", 128'(rlast[i]), 128'(0));
        check("busy_after",   128'(busy[i]),  128'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic reset_mid_write(input int i, input logic [63:0] a, input logic [127:0] d);
        w_valid[i] = 1'b1; waddr[i] = a; wdata[i] = d[63:0]; wlast[i] = 1'b0; b_ready[i] = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_w_beat0", 128'(w_ready[i]), 128'(1));
        @(posedge clock);
        #1 wdata[i] = d[127:64]; wlast[i] = 1'b1; reset[i] = 1'b1;
        @(negedge clock);
        check("rst_in_beat1_busy", 128'(busy[i]), 128'(1));
        @(posedge clock);
        #1 reset[i] = 1'b0; w_valid[i] = 1'b0; wlast[i] = 1'b0; b_ready[i] = 1'b0;
        @(negedge clock);
        check_zero(i);
        peek_check(i, a, "rst_peek_old");
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 2'b11; r_valid = '0; w_valid = '0; wlast = '0; b_ready = '0; init_we = '0;
        raddr = '0; waddr = '0; wdata = '0; init_addr = '0; init_wdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 2'b00;
        @(negedge clock);
        check_zero(0);
        check_zero(1);
        @(posedge clock);
        #1;

        // default latencies
        preload(0, 64'h50, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
        xact(0, 0, 64'h0, 128'h0, 0, 0, 1, 64'h58, 0, 4);
        xact(0, 1, 64'h100, {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001}, 0, 1, 0, 64'h0, 4, 0);
        init_addr[0] = 64'h100;
        #1 check("peek_100_const", peek[0], {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001});
        preload(0, 64'h300, {64'h3333_0000_0000_3001, 64'h3333_0000_0000_3000});
        preload(0, 64'h200, {64'h0BAD_0000_0000_0001, 64'h0BAD_0000_0000_0000});
        xact(0, 1, 64'h200, {64'h2222_0000_0000_2001, 64'h2222_0000_0000_2000}, 0, 1,
             1, 64'h300, 4, 9);
        peek_check(0, 64'h200, "peek_200_updated");

        xact(0, 1, 64'h40, {64'hD0D0_0000_0000_0041, 64'hD0D0_0000_0000_0040}, 0, 1, 0, 64'h0, 4, 0);
        xact(0, 0, 64'h0, 128'h0, 0, 0, 1, 64'h40, 0, 4);
        xact(0, 0, 64'h0, 128'h0, 0, 0, 1, 64'h40 + 64'd1024 * 64'd16, 0, 4);
        xact(0, 1, 64'h40, {64'hE1E1_0000_0000_0041, 64'hE1E1_0000_0000_0040}, 0, 1,
             1, 64'h40, 4, 9);

        // sticky protocol error
        check("proto_before", 128'(proto_err[0]), 128'(0));
        xact(0, 1, 64'h500, {64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000}, 1, 1, 0, 64'h0, 4, 0);
        check("proto_wlast_beat0", 128'(proto_err[0]), 128'(1));
        xact(0, 1, 64'h510, {64'h5151_0000_0000_0001, 64'h5151_0000_0000_0000}, 0, 1,
             1, 64'h500, 4, 9);
        check("proto_sticky", 128'(proto_err[0]), 128'(1));
        do_reset(0);
        check("proto_cleared", 128'(proto_err[0]), 128'(0));
        xact(0, 1, 64'h520, {64'h5252_0000_0000_0001, 64'h5252_0000_0000_0000}, 0, 0, 0, 64'h0, 4, 0);
        check("proto_no_wlast_beat1", 128'(proto_err[0]), 128'(1));
        peek_check(0, 64'h520, "peek_520_committed");
        do_reset(0);

        // reset while in W_BEAT1 discards the write
        preload(0, 64'h600, {64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000});
        xact(0, 0, 64'h0, 128'h0, 0, 0, 1, 64'h600, 0, 4);
        reset_mid_write(0, 64'h600, {64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000});
        xact(0, 0, 64'h0, 128'h0, 0, 0, 1, 64'h600, 0, 4);

        // zero latencies
        preload(1, 64'h80, {64'h8888_0000_0000_0081, 64'h8888_0000_0000_0080});
        xact(1, 0, 64'h0, 128'h0, 0, 0, 1, 64'h80, 0, 1);
        xact(1, 1, 64'h90, {64'h9999_0000_0000_0091, 64'h9999_0000_0000_0090}, 0, 1, 0, 64'h0, 3, 0);
        peek_check(1, 64'h90, "fast_peek_90");
        xact(1, 1, 64'h90, {64'h9A9A_0000_0000_0091, 64'h9A9A_0000_0000_0090}, 0, 1,
             1, 64'h90, 3, 5);
        reset_mid_write(1, 64'h80, {64'hDEAD_0000_0000_0081, 64'hDEAD_0000_0000_0080});
        xact(1, 0, 64'h0, 128'h0, 0, 0, 1, 64'h80, 0, 1);

        check("scoreboard_empty", 128'(rd_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
